// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between a load/store unit (master)
// and the data-memory controller (slave). Cache or bus adapters attach here.
//
// Signals:
//   req_valid/req_ready  request handshake (transfer when both are high)
//   req_we               1 = store, 0 = load
//   req_mask             RISC-V funct3 size/sign code
//   req_addr             byte address, ADDR_W bits
//   req_wdata            right-aligned store data
//   resp_valid/resp_ready response handshake
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_err             access rejected
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_mask;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the load/store stage.
// One access outstanding at a time. A request accepted at edge E0 performs
// its memory access at E0 (store commits, load word is captured), and the
// response is presented LATENCY cycles later until resp_ready is seen.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      dmem_ctrl_if.slave (request and response handshakes)
//
// Parameters: DEPTH_WORDS (power of two, >= 4), LATENCY (1..15), ADDR_W.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses; otherwise the low address bits are truncated.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  dmem_ctrl_if.slave bus
);
  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              init_q;
  logic              accept;

  logic [ADDR_W-3:0] word_idx;
  logic              in_range;
  logic              bad_mask;
  logic              misalign;
  logic              req_err;
  logic              store_ok;
  logic [3:0]        lane_en;
  logic [31:0]       wdata_rep;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_word_q;
  logic [2:0]        mask_q;
  logic [1:0]        off_q;
  logic              err_q;
  logic              zero_q;   // response data forced to 0 (store or error)

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  // init_q keeps req_ready low until the first clock after reset release.
  assign bus.req_ready = init_q && (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  assign word_idx = bus.req_addr[ADDR_W-1:2];
  assign in_range = (word_idx >> IDX_W) == '0;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    bad_mask = 1'b0;
    case (bus.req_mask)
      3'b000, 3'b001, 3'b010: bad_mask = 1'b0;
      3'b100, 3'b101:         bad_mask = bus.req_we;  // no unsigned stores
      default:                bad_mask = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((bus.req_mask[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_mask[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err  = !in_range || bad_mask || misalign;
  assign store_ok = accept && bus.req_we && !req_err;

  // Byte-lane enables; store data is replicated so every lane sees its byte.
  always_comb begin
    lane_en   = 4'b0000;
    wdata_rep = bus.req_wdata;
    case (bus.req_mask[1:0])
      2'b00: begin
        lane_en[bus.req_addr[1:0]] = 1'b1;
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      default: lane_en = 4'b1111;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; contents survive
  // reset, and leaving it out keeps the array mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_q <= mem[word_idx[IDX_W-1:0]];
      if (store_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_en[b]) mem[word_idx[IDX_W-1:0]][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      init_q  <= 1'b0;
      mask_q  <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
      if (accept) begin
        mask_q <= bus.req_mask;
        off_q  <= bus.req_addr[1:0];
        err_q  <= req_err;
        zero_q <= bus.req_we || req_err;
      end
    end
  end

  // cnt_q holds the number of edges since acceptance while in WAIT;
  // leaving at the edge where it equals LATENCY-1 makes the response
  // visible exactly LATENCY cycles after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane select and extension of the captured word.
  always_comb begin
    byte_sel = rd_word_q[8*off_q +: 8];
    half_sel = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (mask_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = rd_word_q;
    endcase
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = zero_q ? 32'd0 : load_data;
  assign bus.resp_err   = err_q;
endmodule
